// File: rtl/soc_system_gpio_debounce.sv
// GPIO input conditioner: per-bit synchroniser and debounce counter feeding the PIO input side,
// with registered rise/fall strobes and an aggregate change strobe.
module soc_system_gpio_debounce #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] bypass,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("soc_system_gpio_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("soc_system_gpio_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
    $error("soc_system_gpio_debounce: CNT_W too small for DEBOUNCE_CYCLES");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  data_q, data_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              any_q, any_d;
  logic [WIDTH-1:0]                  sync_w;

  // Plain shift chain: no logic between synchroniser stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // A differing sample counts up; any matching sample restarts qualification.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bypass[i]) begin
        data_d[i] = sync_w[i];
        cnt_d[i]  = '0;
      end else if (sync_w[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        data_d[i] = sync_w[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
    any_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign data_out   = data_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule
